// File: rtl/rgb_to_sdram.sv
`default_nettype none
// ==================================================================
// rgb_to_sdram : RGB pixel capture into a FIFO, written to DDR as AHB
//                word bursts. RGB_TO_SDRAM_DBUF_EN: alternate bases.
// Rev 1.0 - initial release
// ==================================================================
module rgb_to_sdram #(
  parameter logic [31:0] FRAME_BASE  = 32'h0010_0000,
  parameter logic [31:0] FRAME_BASE1 = 32'h0020_0000,
  parameter int          BURST_LEN   = 16,
  parameter int          FIFO_AW     = 6
) (
  input  logic        clk_ahb,
  input  logic        rst_ahb_n,
  input  logic        cap_en,
  input  logic        v_valid,
  input  logic        de,
  input  logic [7:0]  pixel_r,
  input  logic [7:0]  pixel_g,
  input  logic [7:0]  pixel_b,
  output logic        m_ahb_mastlock,
  output logic [3:0]  m_ahb_prot,
  output logic [2:0]  m_ahb_size,
  output logic [31:0] m_ahb_addr,
  output logic        m_ahb_write,
  output logic [2:0]  m_ahb_burst,
  output logic [1:0]  m_ahb_trans,
  output logic [31:0] m_ahb_wdata,
  input  logic        m_ahb_ready,
  input  logic        m_ahb_resp,
  output logic        frame_done,
  output logic        overflow,
  output logic        bus_err
);
  localparam logic [1:0]       c_tr_idle   = 2'b00;
  localparam logic [1:0]       c_tr_nonseq = 2'b10;
  localparam logic [1:0]       c_tr_seq    = 2'b11;
  localparam logic [2:0]       c_hb_incr   = 3'b001;
  localparam logic [2:0]       c_hb_full   = (BURST_LEN == 4) ? 3'b011 :
                                             (BURST_LEN == 8) ? 3'b101 : 3'b111;
  localparam logic [1:0]       c_st_idle   = 2'd0;
  localparam logic [1:0]       c_st_addr   = 2'd1;
  localparam logic [1:0]       c_st_burst  = 2'd2;
  localparam logic [1:0]       c_st_last   = 2'd3;
  localparam logic [31:0]      c_bl32      = BURST_LEN;
  localparam logic [7:0]       c_bl_m1     = 8'(BURST_LEN - 1);
  localparam logic [FIFO_AW:0] c_depth     = {1'b1, {FIFO_AW{1'b0}}};
`ifdef RGB_TO_SDRAM_DBUF_EN
  localparam logic             c_dbuf      = 1'b1;
`else
  localparam logic             c_dbuf      = 1'b0;
`endif

  logic [31:0]      r_mem [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW:0] r_wptr, r_rptr;
  logic             r_v_d, r_cap_d, r_capturing;
  logic [31:0]      r_push_cnt, r_frame_words, r_written, r_waddr;
  logic             r_pend_end, r_base_sel;
  logic [1:0]       r_state, r_trans;
  logic [2:0]       r_burst;
  logic [7:0]       r_beats_left;
  logic             r_frame_done, r_overflow, r_bus_err;

  logic [FIFO_AW:0] w_level;
  logic [31:0]      w_level32, w_remaining, w_written_nxt, w_cur_base, w_next_base;
  logic             w_v_rise, w_v_fall, w_cap_rise, w_full, w_push_req, w_push, w_pop;
  logic             w_go_full, w_go_incr, w_idle_done, w_last_done, w_done_pulse, w_data_phase;

  assign w_v_rise      = v_valid & ~r_v_d;
  assign w_v_fall      = ~v_valid & r_v_d;
  assign w_cap_rise    = cap_en & ~r_cap_d;
  assign w_level       = r_wptr - r_rptr;
  assign w_level32     = {{(31-FIFO_AW){1'b0}}, w_level};
  assign w_full        = (w_level == c_depth);
  // The rising-edge cycle itself already counts as capturing.
  assign w_push_req    = cap_en & v_valid & de & (r_capturing | w_v_rise);
  assign w_push        = w_push_req & ~w_full;
  assign w_data_phase  = (r_state == c_st_burst) | (r_state == c_st_last);
  assign w_pop         = w_data_phase & m_ahb_ready;
  assign w_remaining   = (r_pend_end ? r_frame_words : r_push_cnt) - r_written;
  assign w_go_full     = (w_remaining >= c_bl32) && (w_level32 >= c_bl32);
  assign w_go_incr     = r_pend_end && (w_remaining != 32'd0) && (w_level32 >= w_remaining);
  assign w_written_nxt = r_written + 32'd1;
  assign w_idle_done   = (r_state == c_st_idle) & cap_en & r_pend_end & (r_written == r_frame_words);
  assign w_last_done   = (r_state == c_st_last) & m_ahb_ready & r_pend_end &
                         (w_written_nxt == r_frame_words);
  assign w_done_pulse  = w_idle_done | w_last_done;
  assign w_cur_base    = r_base_sel ? FRAME_BASE1 : FRAME_BASE;
  assign w_next_base   = (r_base_sel ^ c_dbuf) ? FRAME_BASE1 : FRAME_BASE;

  always_ff @(posedge clk_ahb) begin
    if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= {8'h00, pixel_r, pixel_g, pixel_b};
  end

  always_ff @(posedge clk_ahb or negedge rst_ahb_n) begin
    if (!rst_ahb_n) begin
      r_v_d <= 1'b0;  r_cap_d <= 1'b0;  r_capturing <= 1'b0;
      r_wptr <= '0;   r_rptr <= '0;
      r_push_cnt <= '0;  r_frame_words <= '0;  r_written <= '0;  r_pend_end <= 1'b0;
      r_state <= c_st_idle;  r_trans <= c_tr_idle;  r_burst <= 3'b000;  r_beats_left <= '0;
      r_waddr <= FRAME_BASE;  r_base_sel <= 1'b0;
      r_frame_done <= 1'b0;  r_overflow <= 1'b0;  r_bus_err <= 1'b0;
    end else begin
      r_v_d        <= v_valid;
      r_cap_d      <= cap_en;
      r_frame_done <= 1'b0;
      if (!cap_en || w_v_fall)  r_capturing <= 1'b0;
      else if (w_v_rise)        r_capturing <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push_req && w_full) r_overflow <= 1'b1;
      else if (w_cap_rise)      r_overflow <= 1'b0;
      if (m_ahb_resp)           r_bus_err <= 1'b1;
      else if (w_cap_rise)      r_bus_err <= 1'b0;
      if (w_done_pulse) begin
        r_frame_done <= 1'b1;
        r_waddr      <= w_next_base;
        r_pend_end   <= 1'b0;
        r_written    <= '0;
        r_base_sel   <= r_base_sel ^ c_dbuf;
      end

      case (r_state)
        c_st_idle: begin
          if (!cap_en) begin
            r_rptr     <= r_wptr;
            r_written  <= '0;
            r_pend_end <= 1'b0;
            r_waddr    <= w_cur_base;
          end else if (!w_idle_done && w_go_full) begin
            r_trans      <= c_tr_nonseq;
            r_burst      <= c_hb_full;
            r_beats_left <= c_bl_m1;
            r_state      <= c_st_addr;
          end else if (!w_idle_done && w_go_incr) begin
            r_trans      <= c_tr_nonseq;
            r_burst      <= c_hb_incr;
            r_beats_left <= w_remaining[7:0] - 8'd1;
            r_state      <= c_st_addr;
          end
        end
        c_st_addr, c_st_burst: begin
          if (m_ahb_ready) begin
            r_waddr <= r_waddr + 32'd4;
            if (r_state == c_st_burst) r_written <= w_written_nxt;
            if (r_beats_left == 8'd0) begin
              r_trans <= c_tr_idle;
              r_state <= c_st_last;
            end else begin
              r_trans      <= c_tr_seq;
              r_beats_left <= r_beats_left - 8'd1;
              r_state      <= c_st_burst;
            end
          end
        end
        default: begin
          if (m_ahb_ready) begin
            r_state <= c_st_idle;
            if (!w_last_done) r_written <= w_written_nxt;
          end
        end
      endcase

      // Frame end is applied after completion so a back-to-back end re-arms pend_end.
      if (cap_en && r_capturing && w_v_fall) begin
        r_frame_words <= r_push_cnt;
        r_pend_end    <= 1'b1;
        r_push_cnt    <= '0;
      end else if (!cap_en) begin
        r_push_cnt    <= '0;
      end else if (w_push) begin
        r_push_cnt    <= r_push_cnt + 32'd1;
      end
    end
  end

  assign m_ahb_mastlock = 1'b0;
  assign m_ahb_prot     = 4'b0011;
  assign m_ahb_size     = 3'b010;
  assign m_ahb_trans    = r_trans;
  assign m_ahb_write    = (r_trans != c_tr_idle);
  assign m_ahb_addr     = m_ahb_write ? r_waddr : 32'h0;
  assign m_ahb_burst    = r_burst;
  assign m_ahb_wdata    = w_data_phase ? r_mem[r_rptr[FIFO_AW-1:0]] : 32'h0;
  assign frame_done     = r_frame_done;
  assign overflow       = r_overflow;
  assign bus_err        = r_bus_err;
endmodule
`default_nettype wire
